// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: LEGv8 immediate format codes, 11-bit opcode patterns with
// wildcard masks, and the masked opcode compare used by the decoder.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_D    = 3'd1,
        FMT_CB   = 3'd2,
        FMT_B    = 3'd3,
        FMT_I    = 3'd4,
        FMT_IW   = 3'd5
    } fmt_e;

    // Pattern bits under a 0 in the mask are don't-care operand bits.
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] MASK_D  = 11'b11111111111;

    localparam logic [10:0] OP_CBZ  = 11'b10110100000;
    localparam logic [10:0] OP_CBNZ = 11'b10110101000;
    localparam logic [10:0] MASK_CB = 11'b11111111000;

    localparam logic [10:0] OP_B    = 11'b00010100000;
    localparam logic [10:0] MASK_B  = 11'b11111100000;

    localparam logic [10:0] OP_ADDI = 11'b10010001000;
    localparam logic [10:0] OP_SUBI = 11'b11010001000;
    localparam logic [10:0] MASK_I  = 11'b11111111110;

    localparam logic [10:0] OP_MOVZ = 11'b11010010100;
    localparam logic [10:0] MASK_IW = 11'b11111111100;

    function automatic logic op_match(input logic [10:0] op,
                                      input logic [10:0] pat,
                                      input logic [10:0] mask);
        return ((op ^ pat) & mask) == 11'd0;
    endfunction

endpackage

// File: rtl/imm_fmt_decode.sv
// imm_fmt_decode: purely combinational opcode (instr[31:21]) to format decode.
module imm_fmt_decode
    import imm_gen_pkg::*;
(
    input  logic [10:0] opcode,
    output fmt_e        fmt
);

    // NOTE: every output of an always_comb gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        fmt = FMT_NONE;
        if (op_match(opcode, OP_LDUR, MASK_D) || op_match(opcode, OP_STUR, MASK_D))
            fmt = FMT_D;
        else if (op_match(opcode, OP_CBZ, MASK_CB) || op_match(opcode, OP_CBNZ, MASK_CB))
            fmt = FMT_CB;
        else if (op_match(opcode, OP_B, MASK_B))
            fmt = FMT_B;
        else if (op_match(opcode, OP_ADDI, MASK_I) || op_match(opcode, OP_SUBI, MASK_I))
            fmt = FMT_I;
        else if (op_match(opcode, OP_MOVZ, MASK_IW))
            fmt = FMT_IW;
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: two-stage elastic LEGv8 immediate generator (S1 decode, S2 extend).
// Optional saturating illegal-instruction counter enabled by IMMGEN_ERRCNT_EN.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ERRCNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] imm,
    output fmt_e                  fmt,
    output logic                  illegal
`ifdef IMMGEN_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0]   err_cnt
`endif
);

    if ((DATA_WIDTH != 32 && DATA_WIDTH != 64) || ERRCNT_W < 1) begin : g_param_check
        $error("imm_gen_pipe: DATA_WIDTH must be 32 or 64 and ERRCNT_W at least 1");
    end

    logic        s1_valid, s2_valid;
    logic        s1_load, s2_load;
    logic [25:0] s1_field;
    fmt_e        s1_fmt, dec_fmt;

    logic [DATA_WIDTH-1:0] s2_imm;
    fmt_e                  s2_fmt;
    logic                  s2_illegal;
    logic [63:0]           imm_full;

    // A stage loads when it is empty or its contents move on this cycle.
    assign s2_load  = !s2_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    imm_fmt_decode u_fmt_decode (
        .opcode (instr[31:21]),
        .fmt    (dec_fmt)
    );

    // The opcode is consumed by the decoder, so S1 keeps only the operand bits.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_field <= '0;
            s1_fmt   <= FMT_NONE;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_field <= instr[25:0];
                s1_fmt   <= dec_fmt;
            end
        end
    end

    always_comb begin
        imm_full = '0;
        case (s1_fmt)
            FMT_D:   imm_full = {{55{s1_field[20]}}, s1_field[20:12]};
            FMT_CB:  imm_full = {{43{s1_field[23]}}, s1_field[23:5], 2'b00};
            FMT_B:   imm_full = {{36{s1_field[25]}}, s1_field[25:0], 2'b00};
            FMT_I:   imm_full = {52'd0, s1_field[21:10]};
            FMT_IW:  imm_full = {48'd0, s1_field[20:5]} << {s1_field[22:21], 4'b0000};
            default: imm_full = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid   <= 1'b0;
            s2_imm     <= '0;
            s2_fmt     <= FMT_NONE;
            s2_illegal <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_imm     <= imm_full[DATA_WIDTH-1:0];
                s2_fmt     <= s1_fmt;
                s2_illegal <= (s1_fmt == FMT_NONE);
            end
        end
    end

    assign out_valid = s2_valid;
    assign imm       = s2_imm;
    assign fmt       = s2_fmt;
    assign illegal   = s2_illegal;

`ifdef IMMGEN_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_q;

    // Counts consumed illegal results only; sticks at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= '0;
        end else if (s2_valid && out_ready && s2_illegal && (err_q != {ERRCNT_W{1'b1}})) begin
            err_q <= err_q + 1'b1;
        end
    end

    assign err_cnt = err_q;
`endif

endmodule
